// File: rtl/rwc_chal_sched.sv
// Challenge scheduler / response collector for the read-write collision PUF generator.
// Optional RWC_VOTE_EN: three evaluations per address, bitwise-majority response.
module rwc_chal_sched #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_num_chal,
  input  logic [DATA_W-1:0] i_seed,
  output logic              o_gen_enable,
  output logic [DATA_W-1:0] o_cha_data,
  output logic [ADDR_W-1:0] o_cha_addr,
  input  logic              i_available,
  input  logic [DATA_W-1:0] i_rsp_pos,
  input  logic [DATA_W-1:0] i_rsp_neg,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_rsp_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(32'h80200003);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WBUSY, S_WIDLE, S_SETTLE, S_OUT, S_DONE
  } state_t;

  state_t              r_state, w_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_num, r_idx;
  logic [DATA_W-1:0]   r_lfsr, r_rsp;
  logic [TW-1:0]       r_tcnt;
  logic                r_err;
  logic                w_tlast, w_tmo, w_last, w_last_ev;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_xor;

`ifdef RWC_VOTE_EN
  logic [1:0]          r_ev;
  logic [DATA_W-1:0]   r_w0, r_w1;
  assign w_last_ev = (r_ev == 2'd2);
`else
  assign w_last_ev = 1'b1;
`endif

  assign w_tlast = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_last  = (r_idx == r_num - 1'b1);
  assign w_addr  = r_base + r_idx[ADDR_W-1:0];
  assign w_xor   = i_rsp_pos ^ i_rsp_neg;

  always_comb begin
    w_nxt = r_state;
    w_tmo = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_nxt = (i_num_chal == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:  if (i_available) w_nxt = S_WBUSY;
      S_WBUSY:  if (!i_available) w_nxt = S_WIDLE;
                else if (w_tlast) begin w_tmo = 1'b1; w_nxt = S_DONE; end
      S_WIDLE:  if (i_available) w_nxt = S_SETTLE;
                else if (w_tlast) begin w_tmo = 1'b1; w_nxt = S_DONE; end
      S_SETTLE: w_nxt = w_last_ev ? S_OUT : S_ISSUE;
      S_OUT:    if (i_rsp_ready) w_nxt = w_last ? S_DONE : S_ISSUE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_num   <= '0;
      r_idx   <= '0;
      r_lfsr  <= DATA_W'(1);
      r_rsp   <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
`ifdef RWC_VOTE_EN
      r_ev    <= '0;
      r_w0    <= '0;
      r_w1    <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      // Phase timer restarts whenever the state changes.
      r_tcnt  <= (w_nxt == r_state && (r_state == S_WBUSY || r_state == S_WIDLE))
                 ? r_tcnt + 1'b1 : '0;
      if (w_tmo) r_err <= 1'b1;
      if (r_state == S_IDLE && i_start) begin
        r_base <= i_base_addr;
        r_num  <= i_num_chal;
        r_idx  <= '0;
        r_lfsr <= (i_seed == '0) ? DATA_W'(1) : i_seed;
        r_err  <= 1'b0;
`ifdef RWC_VOTE_EN
        r_ev   <= '0;
`endif
      end
      if (r_state == S_OUT && i_rsp_ready) begin
        r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : '0);
        r_idx  <= r_idx + 1'b1;
      end
`ifdef RWC_VOTE_EN
      if (r_state == S_SETTLE) begin
        case (r_ev)
          2'd0:    r_w0  <= w_xor;
          2'd1:    r_w1  <= w_xor;
          default: r_rsp <= (r_w0 & r_w1) | (r_w0 & w_xor) | (r_w1 & w_xor);
        endcase
        r_ev <= w_last_ev ? 2'd0 : r_ev + 1'b1;
      end
`else
      if (r_state == S_SETTLE) r_rsp <= w_xor;
`endif
    end
  end

  // Challenge outputs are gated so the reset/idle view is all zeros.
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_gen_enable = (r_state == S_ISSUE) && i_available;
  assign o_rsp_valid  = (r_state == S_OUT);
  assign o_cha_data   = o_busy ? r_lfsr : '0;
  assign o_cha_addr   = o_busy ? w_addr : '0;
  assign o_rsp_addr   = o_busy ? w_addr : '0;
  assign o_rsp_data   = r_rsp;
  assign o_err        = r_err;
endmodule

// File: tb/tb_rwc_chal_sched.sv
// Scoreboard bench for rwc_chal_sched with a behavioural collision-generator model.
module tb_rwc_chal_sched;
  localparam int AW = 10, DW = 32, TMO = 16;
`ifdef RWC_VOTE_EN
  localparam int NEV = 3;
`else
  localparam int NEV = 1;
`endif

  logic          clk = 0, rst = 0, start = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_chal = '0;
  logic [DW-1:0] seed = '0;
  logic          gen_enable, rsp_valid, busy, done, err;
  logic [DW-1:0] cha_data, rsp_data;
  logic [AW-1:0] cha_addr, rsp_addr;
  logic          available = 1;
  logic [DW-1:0] rsp_pos = '0, rsp_neg = '0;
  logic          rdy_man = 1, rnd_rdy = 0, rnd_bit = 1;
  wire           rsp_ready = rnd_rdy ? rnd_bit : rdy_man;
  bit            stuck = 0;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } ent_t;
  ent_t chq[$], rq[$];
  int n_chk = 0, n_err = 0, n_ge = 0, n_done = 0, cyc = 0, ge_cyc = 0, done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rwc_chal_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_chal(num_chal), .i_seed(seed), .o_gen_enable(gen_enable),
    .o_cha_data(cha_data), .o_cha_addr(cha_addr), .i_available(available),
    .i_rsp_pos(rsp_pos), .i_rsp_neg(rsp_neg), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_addr(rsp_addr),
    .o_busy(busy), .o_done(done), .o_err(err));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] step(input logic [DW-1:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Generator XOR word for a challenge; data=1, addr=0 gives 0xFF.
  function automatic logic [DW-1:0] xw(input logic [DW-1:0] d, input logic [AW-1:0] a);
    return (d * 32'hFF) ^ DW'(a);
  endfunction

  // Disjoint per-evaluation disturbances: the majority recovers the clean word.
  function automatic logic [DW-1:0] pert(input int ev);
    case (ev)
      1:       return 32'h0F0F0000;
      2:       return 32'h000000F0;
      default: return 32'h0;
    endcase
  endfunction

  int g_st = 0, g_cnt = 0, g_len = 2, g_ev = 0;
  logic [DW-1:0] g_word;
  always @(posedge clk) begin
    #1;
    if (!rst) g_ev = 0;
    if (stuck) begin
      available = 1; g_st = 0;
    end else case (g_st)
      0: if (gen_enable) begin
           g_word = xw(cha_data, cha_addr) ^ pert(g_ev);
           g_ev   = (g_ev + 1) % NEV;
           g_len  = $urandom_range(1, 4);
           g_st   = 1;
         end
      1: begin available = 0; g_cnt = 0; g_st = 2; end
      default: begin
        g_cnt++;
        if (g_cnt >= g_len) begin
          available = 1; rsp_pos = 32'hA5A50000; rsp_neg = 32'hA5A50000 ^ g_word; g_st = 0;
        end
      end
    endcase
  end

  always @(posedge clk) begin #1; rnd_bit = 1'($urandom_range(0, 1)); end

  always @(negedge clk) if (rst) begin
    ent_t e;
    if (gen_enable) begin
      n_ge++; ge_cyc = cyc;
      if (chq.size() == 0) chk("ge_unexpected", 1, 0);
      else begin
        e = chq.pop_front();
        chk("cha_data", cha_data, e.data);
        chk("cha_addr", cha_addr, e.addr);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_addr", rsp_addr, e.addr);
      end
    end
    if (done) begin n_done++; done_cyc = cyc; end
  end

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] s,
                        input bit stk);
    logic [DW-1:0] l;
    ent_t e;
    l = (s == 0) ? 32'h1 : s;
    for (int i = 0; i < int'(n); i++) begin
      e.addr = AW'(int'(b) + i);
      e.data = l;
      for (int k = 0; k < NEV; k++) begin
        chq.push_back(e);
        if (stk) break;
      end
      if (stk) break;
      e.data = xw(l, e.addr);
      rq.push_back(e);
      l = step(l);
    end
    base_addr = b; num_chal = n; seed = s; start = 1;
    @(posedge clk); #1; start = 0;
  endtask

  task automatic wait_done(input int d0, output int t);
    t = 0;
    while (n_done == d0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (n_done == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic wrap(input string tag, input int d0, input int g0, input int exp_ge);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, n_done - d0, 1);
    chk({tag, "_ge_count"}, n_ge - g0, exp_ge);
    chk({tag, "_q_empty"}, chq.size() + rq.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] b, input logic [AW:0] n,
                     input logic [DW-1:0] s);
    int d0, g0, t;
    d0 = n_done; g0 = n_ge;
    launch(b, n, s, 0);
    wait_done(d0, t);
    wrap(tag, d0, g0, int'(n) * NEV);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int d0, g0, g1, t;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    #12;
    chk("rst_ctrl", {gen_enable, rsp_valid, busy, done, err}, 5'b0);
    chk("rst_cha", {cha_data, cha_addr}, '0);
    chk("rst_rsp", {rsp_data, rsp_addr}, '0);
    @(posedge clk); #1; rst = 1;
    repeat (2) @(posedge clk);
    #1;

    run("t1", 10'h000, 11'd1, 32'h1);
    run("t2", 10'h3FE, 11'd4, 32'h1);

    rdy_man = 0; d0 = n_done; g0 = n_ge;
    launch(10'h010, 11'd2, 32'h1234, 0);
    t = 0;
    while (!rsp_valid && t < 500) begin @(posedge clk); #1; t++; end
    chk("t3_valid", rsp_valid, 1);
    hd = rsp_data; ha = rsp_addr; g1 = n_ge;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t3_hold", {rsp_valid, rsp_addr, rsp_data}, {1'b1, ha, hd});
    end
    chk("t3_no_ge", n_ge, g1);
    rdy_man = 1;
    wait_done(d0, t);
    wrap("t3", d0, g0, 2 * NEV);

    stuck = 1; d0 = n_done; g0 = n_ge;
    launch(10'h020, 11'd3, 32'h55, 1);
    wait_done(d0, t);
    chk("t4_err", err, 1);
    chk("t4_latency", done_cyc - ge_cyc, TMO + 1);
    wrap("t4", d0, g0, 1);
    stuck = 0;
    d0 = n_done; g0 = n_ge;
    launch(10'h030, 11'd1, 32'h77, 0);
    chk("t4_err_clear", err, 0);
    wait_done(d0, t);
    wrap("t4b", d0, g0, NEV);

    launch(10'h2A0, 11'd3, 32'hDEAD, 0);
    t = 0;
    while (available && t < 200) begin @(posedge clk); #2; t++; end
    chk("t5_gen_busy", available, 0);
    @(posedge clk); #2;
    rst = 0; #1;
    chk("t5_rst_ctrl", {gen_enable, rsp_valid, busy, done, err}, 5'b0);
    chk("t5_rst_cha", {cha_data, cha_addr}, '0);
    chk("t5_rst_rsp", {rsp_data, rsp_addr}, '0);
    chq.delete(); rq.delete();
    @(posedge clk); #1; rst = 1;
    g0 = n_ge;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_quiet", {busy, 32'(n_ge - g0)}, 33'b0);
    run("t5", 10'h155, 11'd1, 32'h0BAD);

    d0 = n_done; g0 = n_ge;
    launch(10'h100, 11'd0, 32'h9, 0);
    wait_done(d0, t);
    chk("t6_fast", t <= 2, 1);
    wrap("t6", d0, g0, 0);

    run("seed0", 10'h100, 11'd2, 32'h0);
    rnd_rdy = 1;
    for (int k = 0; k < 4; k++)
      run("rnd", AW'($urandom), 11'($urandom_range(1, 5)), $urandom);
    rnd_rdy = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
